wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline Writeback stage and one long-latency result source, such as a multi-cycle multiply/divide unit or a load-miss return path.
- The pipeline has default priority. The long source takes free slots through a valid/ready handshake.
- A starvation counter forces a pipeline stall so that the long source always makes progress.
- Sits between the Writeback result mux output and the register-file write port.

---
 rtl/wb_port_arbiter_pkg.sv | 18 +
 rtl/wb_starve_counter.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the Writeback write-port arbiter.
// The hazard unit also uses REG_ZERO for its own x0 checks.
package wb_port_arbiter_pkg;

  // Arbiter mode: NORMAL gives the pipeline priority. FORCE grants one
  // stalled slot to the long source.
  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_arb_state_t;

  // Architectural zero register. Writes to it are discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the starvation counter. STARVE_MAX must fit in it (1..15).
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating counter of consecutive cycles in which the long source was
// refused the write port. It flags when the next increment would reach
// STARVE_MAX.
module wb_starve_counter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_i,
  input  logic                    clr_i,
  output logic [STARVE_CNT_W-1:0] cnt_o,
  output logic                    hit_o
);

  localparam logic [STARVE_CNT_W-1:0] CNT_SAT = '1;
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Increment value, saturating at all-ones so the count never wraps.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // hit_o looks only at the incremented value and does not depend on inc_i.
  // This keeps the path to the arbiter's next-state logic free of loops.
  assign hit_o = (cnt_inc == CNT_MAX);
  assign cnt_o = cnt_q;

  // Next-count selection: a clear wins over an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_inc;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) assignment so
    // every flop samples pre-edge values regardless of block ordering.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// pipeline Writeback stage and one long-latency result source.
// The pipeline has priority. The long source takes free slots. After
// STARVE_MAX refused cycles, one stalled FORCE cycle guarantees progress.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [WIDTH-1:0]  ResultW,
  input  logic              LongValid,
  input  logic [ADDR_W-1:0] LongRd,
  input  logic [WIDTH-1:0]  LongData,
  output logic              LongReady,
  output logic              RegWriteOut,
  output logic [ADDR_W-1:0] RdOut,
  output logic [WIDTH-1:0]  WDataOut,
  output logic              StallReq
);

  localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);

  wb_arb_state_t           state_q, state_d;
  logic                    pipe_wr;
  logic                    long_wr;
  logic                    long_sel;
  logic                    cnt_inc;
  logic                    cnt_clr;
  logic                    cnt_hit;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  // A write to x0 is not a real write on either side.
  assign pipe_wr = RegWriteW && (RdW != RD_ZERO);
  assign long_wr = LongValid && (LongRd != RD_ZERO);

  wb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .cnt_o (starve_cnt),
    .hit_o (cnt_hit)
  );

  // Write-port select, handshake, stall request and next-state decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned. Otherwise synthesis would infer a latch.
    state_d     = state_q;
    LongReady   = 1'b0;
    RegWriteOut = 1'b0;
    RdOut       = '0;
    WDataOut    = '0;
    StallReq    = 1'b0;
    long_sel    = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;

    // During reset, all outputs stay at their quiet defaults.
    if (!rst) begin
      unique case (state_q)
        NORMAL: begin
          if (pipe_wr) begin
            RegWriteOut = 1'b1;
            RdOut       = RdW;
            WDataOut    = ResultW;
          end else begin
            LongReady = 1'b1;
            long_sel  = 1'b1;
          end
          // A refused long result counts toward starvation.
          // A transfer or an idle source clears the count.
          if (LongValid && !LongReady) begin
            cnt_inc = 1'b1;
            if (cnt_hit) begin
              state_d = FORCE;
            end
          end else begin
            cnt_clr = 1'b1;
          end
        end
        FORCE: begin
          // StallReq comes straight from the state register.
          StallReq  = 1'b1;
          LongReady = 1'b1;
          long_sel  = 1'b1;
          // LongReady is 1 here, so the cycle ends in a transfer or with
          // LongValid low. Either way FORCE lasts one cycle.
          cnt_clr   = 1'b1;
          state_d   = NORMAL;
        end
        default: state_d = NORMAL;
      endcase

      if (long_sel && long_wr) begin
        RegWriteOut = 1'b1;
        RdOut       = LongRd;
        WDataOut    = LongData;
      end
    end
  end

  // Arbiter state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
